// File: rtl/matrix_add4_sched.sv
// matrix_add4_sched: folds a stream of N HxW fixed-point matrices into one sum
// using an external shared 4-input combinational matrix adder.
// Operands are collected into four slot registers (add_a..add_d); each round
// fires the adder once, and the partial sum re-enters as slot 0 of the next
// round. Unwritten slots stay zero and act as padding.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, num_terms      job request (IDLE only) and term count (clamped to MAX_TERMS)
//   in_valid/in_ready     operand handshake, in_data operand matrix
//   add_a..add_d          slot registers feeding the adder, add_y adder result
//   out_valid/out_ready   result handshake, out_data final sum
//   busy                  high whenever not IDLE
//   perf_cycles           busy-cycle counter for the current job
//                         (present only when MATADD_SCHED_PERF_EN is defined)
module matrix_add4_sched #(
  parameter int unsigned H           = 4,
  parameter int unsigned W           = 3,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRACT_WIDTH = 8,
  parameter int unsigned MAX_TERMS   = 16,
  parameter int unsigned CW          = $clog2(MAX_TERMS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CW-1:0]                num_terms,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [H*W*DATA_WIDTH-1:0]    in_data,
  output logic [H*W*DATA_WIDTH-1:0]    add_a,
  output logic [H*W*DATA_WIDTH-1:0]    add_b,
  output logic [H*W*DATA_WIDTH-1:0]    add_c,
  output logic [H*W*DATA_WIDTH-1:0]    add_d,
  input  logic [H*W*DATA_WIDTH-1:0]    add_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [H*W*DATA_WIDTH-1:0]    out_data,
  output logic                         busy
`ifdef MATADD_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int unsigned MW = H * W * DATA_WIDTH;

  // Fixed-point format sanity; the block itself never interprets element bits.
  if (FRACT_WIDTH > DATA_WIDTH) begin : g_fract_check
    $error("FRACT_WIDTH must not exceed DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [2:0]      idx_q, idx_d;
  logic [MW-1:0]   slot_q [4];
  logic [MW-1:0]   slot_d [4];
  logic [MW-1:0]   out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   n_clamped_c;
  logic            in_hs_c;

  assign n_clamped_c = (num_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : num_terms;
  assign in_hs_c     = in_valid && in_ready_q;

  // Next-state, slot and output-register logic.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    out_data_d = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_terms == '0) begin
            out_data_d = '0;
            state_d    = S_OUT;
          end else begin
            rem_d = n_clamped_c;
            idx_d = 3'd0;
            for (int i = 0; i < 4; i++) slot_d[i] = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Leave one cycle after the filling handshake so the slots settle
        // before the adder result is taken.
        if ((idx_q == 3'd4) || (rem_q == '0)) begin
          state_d = S_ADD;
        end else if (in_hs_c) begin
          for (int i = 0; i < 4; i++) begin
            if (idx_q == 3'(i)) slot_d[i] = in_data;
          end
          idx_d = idx_q + 3'd1;
          rem_d = rem_q - CW'(1);
        end
      end
      S_ADD: begin
        if (rem_q != '0) begin
          slot_d[0] = add_y;
          slot_d[1] = '0;
          slot_d[2] = '0;
          slot_d[3] = '0;
          idx_d     = 3'd1;
          state_d   = S_LOAD;
        end else begin
          out_data_d = add_y;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered, so derive them from the next state.
    in_ready_d  = (state_d == S_LOAD) && (rem_d != '0) && (idx_d < 3'd4);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      idx_q       <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MATADD_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle count: cleared on accepted start, saturating, frozen once idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign add_a     = slot_q[0];
  assign add_b     = slot_q[1];
  assign add_c     = slot_q[2];
  assign add_d     = slot_q[3];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_matrix_add4_sched.sv
// Self-checking bench for matrix_add4_sched with a wrapping 4-input adder model.
module tb_matrix_add4_sched;
  localparam int unsigned H  = 4;
  localparam int unsigned W  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned MT = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned NE = H * W;
  localparam int unsigned MW = NE * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_terms;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_data;
  logic [MW-1:0] add_a, add_b, add_c, add_d, add_y;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_data;
  logic          busy;
`ifdef MATADD_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  matrix_add4_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_d     (add_d),
    .add_y     (add_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef MATADD_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // External adder: element-wise four-way sum, wrapping at DW bits.
  always_comb begin
    add_y = '0;
    for (int e = 0; e < NE; e++)
      add_y[e*DW +: DW] = add_a[e*DW +: DW] + add_b[e*DW +: DW]
                        + add_c[e*DW +: DW] + add_d[e*DW +: DW];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] splat(input logic [15:0] v);
    logic [MW-1:0] r;
    for (int e = 0; e < NE; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] r;
    for (int e = 0; e < NE; e++) r[e*DW +: DW] = 16'($urandom);
    return r;
  endfunction

  logic [MW-1:0] op_q  [$];
  logic [MW-1:0] exp_q [$];

  // Reference: per element, integer sum of all operands modulo 2^DW.
  function automatic logic [MW-1:0] model_sum();
    logic [MW-1:0] r;
    for (int e = 0; e < NE; e++) begin
      int unsigned acc;
      acc = 0;
      foreach (op_q[k]) acc += int'(op_q[k][e*DW +: DW]);
      r[e*DW +: DW] = 16'(acc % 65536);
    end
    return r;
  endfunction

  // Output monitor: every valid cycle is compared against the model queue.
  logic          ov_prev = 1'b0;
  logic [MW-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_out", MW'(in_ready), MW'(1'b0));
        check("busy_in_out", MW'(busy), MW'(1'b1));
        if (!ov_prev) begin
          check("out_expected", MW'(exp_q.size() != 0), MW'(1'b1));
          if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
          held <= out_data;
        end else begin
          check("out_stable", out_data, held);
        end
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      ov_prev <= out_valid;
    end
  end

  logic [MW-1:0] cap_out, cap_bcd, cap_a_r2;
  logic          saw_ready;

  // Runs one job from a posedge+1 point and returns at posedge+1 after the
  // output handshake (or after the reset when aborting).
  task automatic run_job(input int n_req, input int stall_mode, input int hold,
                         input bit pulse_start, input int abort_after);
    int n_eff, c0, guard, lat, r, exp_lat;
    bit hs;
    n_eff = (n_req > int'(MT)) ? int'(MT) : n_req;
    exp_q.push_back(model_sum());
    start     = 1'b1;
    num_terms = CW'(n_req);
    c0        = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    saw_ready = in_ready;
    for (int i = 0; i < n_eff; i++) begin
      int idle;
      idle = 0;
      if (stall_mode == 1 && i > 0) idle = 2;
      if (stall_mode == 2) idle = int'($urandom_range(0, 2));
      for (int s = 0; s < idle; s++) begin
        in_valid = 1'b0;
        in_data  = rand_mat();
        @(posedge clk); #1;
        saw_ready |= in_ready;
      end
      in_valid = 1'b1;
      in_data  = op_q[i];
      guard    = 0;
      do begin
        hs = in_ready;
        saw_ready |= in_ready;
        if (hs && i == 4) cap_a_r2 = add_a;
        @(posedge clk); #1;
        guard++;
      end while (!hs && guard < 100);
      if (!hs) begin
        check("load_timeout", MW'(hs), MW'(1'b1));
        break;
      end
      if (abort_after == i + 1) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", MW'(in_ready), MW'(1'b0));
        check("abort_busy", MW'(busy), MW'(1'b0));
        check("abort_add_a", add_a, '0);
        check("abort_add_bcd", add_b | add_c | add_d, '0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      saw_ready |= in_ready;
      @(posedge clk); #1;
      guard++;
    end
    check("out_timeout", MW'(out_valid), MW'(1'b1));
    lat = cyc - c0;
    r   = (n_eff > 4) ? 1 + (n_eff - 4 + 2) / 3 : 1;
    exp_lat = (n_eff == 0) ? 1 : 1 + n_eff + 2 * r;
    if (stall_mode == 0) check("latency", MW'(lat), MW'(exp_lat));
    cap_out = out_data;
    cap_bcd = add_b | add_c | add_d;
    for (int h = 0; h < hold; h++) begin
      start = pulse_start;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_hold", MW'(busy), MW'(1'b1));
      check("valid_hold", MW'(out_valid), MW'(1'b1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after", MW'({busy, out_valid}), MW'(2'b00));
`ifdef MATADD_SCHED_PERF_EN
    check("perf_cycles", MW'(perf_cycles), MW'(cyc - 1 - c0));
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_terms = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", MW'(in_ready), MW'(1'b0));
    check("rst_out_valid", MW'(out_valid), MW'(1'b0));
    check("rst_busy", MW'(busy), MW'(1'b0));
    check("rst_out_data", out_data, '0);
    check("rst_slots", add_a | add_b | add_c | add_d, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_q = '{splat(16'h0040), splat(16'h0040), splat(16'h0080), splat(16'h0080)};
    run_job(4, 0, 0, 1'b0, 0);
    check("n4_result", cap_out, splat(16'h0180));

    op_q.delete();
    repeat (7) op_q.push_back(splat(16'h0100));
    run_job(7, 0, 0, 1'b0, 0);
    check("n7_round2_slot0", cap_a_r2, splat(16'h0400));
    check("n7_result", cap_out, splat(16'h0700));

    op_q = '{splat(16'hFFC0)};
    run_job(1, 0, 0, 1'b0, 0);
    check("n1_pad_zero", cap_bcd, '0);
    check("n1_result", cap_out, splat(16'hFFC0));

    op_q.delete();
    run_job(0, 0, 0, 1'b0, 0);
    check("n0_result", cap_out, '0);
    check("n0_no_ready", MW'(saw_ready), MW'(1'b0));

    op_q.delete();
    repeat (5) op_q.push_back(splat(16'h0040));
    run_job(5, 1, 5, 1'b1, 0);
    check("n5_backpressure", cap_out, splat(16'h0140));

    op_q.delete();
    repeat (4) op_q.push_back(rand_mat());
    run_job(4, 0, 0, 1'b0, 2);

    op_q = '{splat(16'h0001), splat(16'h0010), splat(16'h0100), splat(16'h1000)};
    run_job(4, 0, 0, 1'b0, 0);
    check("after_abort_result", cap_out, splat(16'h1111));

    for (int j = 0; j < 30; j++) begin
      int n, ne;
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31))
                                       : int'($urandom_range(0, 16));
      ne = (n > int'(MT)) ? int'(MT) : n;
      op_q.delete();
      for (int k = 0; k < ne; k++) op_q.push_back(rand_mat());
      run_job(n, ($urandom_range(0, 1) == 1) ? 2 : 0,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
